// File: rtl/reg_status_pkg.sv
// Shared widths and struct types for the rename/busy-table and the ROB interface.
package reg_status_pkg;

  localparam int TAG_WIDTH      = 3;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef struct packed {
    logic                      stall;
    logic                      flush;
    logic                      issue_en;
    logic [REG_ADDR_WIDTH-1:0] issue_rd;
    logic [TAG_WIDTH-1:0]      issue_tag;
    logic                      commit_en;
    logic [REG_ADDR_WIDTH-1:0] commit_dest;
    logic [TAG_WIDTH-1:0]      commit_tag;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
  } reg_status_in;

  typedef struct packed {
    logic                    rs1_busy;
    logic [TAG_WIDTH-1:0]    rs1_tag;
    logic                    rs2_busy;
    logic [TAG_WIDTH-1:0]    rs2_tag;
    logic [REG_ADDR_WIDTH:0] pending_cnt;
  } reg_status_out;

  typedef struct packed {
    logic                      alloc;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic                      done;
    logic [TAG_WIDTH-1:0]      done_tag;
  } rob_in;

  typedef struct packed {
    logic                      full;
    logic [TAG_WIDTH-1:0]      tail_tag;
    logic [TAG_WIDTH-1:0]      head_tag;
    logic [REG_ADDR_WIDTH-1:0] head_dest;
    logic                      reg_en;
  } rob_out;

endpackage

// File: rtl/reg_status_lookup.sv
// One combinational read port into the busy/tag table. x0 always reads idle.
module reg_status_lookup #(
  parameter int TAG_WIDTH      = reg_status_pkg::TAG_WIDTH,
  parameter int REG_ADDR_WIDTH = reg_status_pkg::REG_ADDR_WIDTH,
  parameter int NUM_REGS       = 1 << REG_ADDR_WIDTH
) (
  input  logic [NUM_REGS-1:0]                busy,
  input  logic [NUM_REGS-1:0][TAG_WIDTH-1:0] tags,
  input  logic [REG_ADDR_WIDTH-1:0]          addr,
  output logic                               rd_busy,
  output logic [TAG_WIDTH-1:0]               rd_tag
);
  import reg_status_pkg::*;

  // Tag is forced to zero whenever the entry is not pending.
  always_comb begin
    rd_busy = 1'b0;
    rd_tag  = '0;
    if (addr != '0 && busy[addr]) begin
      rd_busy = 1'b1;
      rd_tag  = tags[addr];
    end
  end

endmodule

// File: rtl/reg_status.sv
// Register status table: per-register busy bit and producing ROB tag, two
// lookup ports, and a registered count of pending registers.
module reg_status #(
  parameter int TAG_WIDTH      = reg_status_pkg::TAG_WIDTH,
  parameter int REG_ADDR_WIDTH = reg_status_pkg::REG_ADDR_WIDTH,
  parameter int NUM_REGS       = 1 << REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      issue_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd_i,
  input  logic [TAG_WIDTH-1:0]      issue_tag_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic                      rs1_busy_o,
  output logic                      rs2_busy_o,
  output logic [TAG_WIDTH-1:0]      rs1_tag_o,
  output logic [TAG_WIDTH-1:0]      rs2_tag_o,
  input  logic                      commit_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] commit_dest_i,
  input  logic [TAG_WIDTH-1:0]      commit_tag_i,
  output logic [REG_ADDR_WIDTH:0]   pending_cnt_o
);
  import reg_status_pkg::*;

  localparam int CW = REG_ADDR_WIDTH + 1;

  logic [NUM_REGS-1:0]                busy_q, busy_n;
  logic [NUM_REGS-1:0][TAG_WIDTH-1:0] tag_q, tag_n;
  logic [CW-1:0]                      cnt_n;
  logic                               do_issue, do_commit, inc, dec;

  // Next-state of the table; issue is applied after commit so it wins on a
  // same-register collision. Commit only retires the current owner's tag.
  always_comb begin
    busy_n    = busy_q;
    tag_n     = tag_q;
    do_issue  = issue_en_i && !stall_i && !flush_i && (issue_rd_i != '0);
    do_commit = commit_en_i && !stall_i && !flush_i && (commit_dest_i != '0) &&
                busy_q[commit_dest_i] && (tag_q[commit_dest_i] == commit_tag_i);
    inc       = do_issue && !busy_q[issue_rd_i];
    dec       = do_commit && !(do_issue && (issue_rd_i == commit_dest_i));
    if (do_commit) begin
      busy_n[commit_dest_i] = 1'b0;
      tag_n[commit_dest_i]  = '0;
    end
    if (do_issue) begin
      busy_n[issue_rd_i] = 1'b1;
      tag_n[issue_rd_i]  = issue_tag_i;
    end
    cnt_n = pending_cnt_o + CW'(inc) - CW'(dec);
  end

  // State update; reset beats flush, flush beats everything else.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      busy_q        <= '0;
      tag_q         <= '0;
      pending_cnt_o <= '0;
    end else begin
      busy_q        <= busy_n;
      tag_q         <= tag_n;
      pending_cnt_o <= cnt_n;
    end
  end

  // The counter tracks busy bits, so it can neither pass NUM_REGS-1 nor underflow.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (!(dec && !inc && pending_cnt_o == '0));
      assert (!(inc && !dec && pending_cnt_o >= CW'(NUM_REGS - 1)));
    end
  end

  reg_status_lookup #(
    .TAG_WIDTH(TAG_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_rs1 (
    .busy(busy_q), .tags(tag_q), .addr(rs1_addr_i),
    .rd_busy(rs1_busy_o), .rd_tag(rs1_tag_o)
  );

  reg_status_lookup #(
    .TAG_WIDTH(TAG_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_rs2 (
    .busy(busy_q), .tags(tag_q), .addr(rs2_addr_i),
    .rd_busy(rs2_busy_o), .rd_tag(rs2_tag_o)
  );

endmodule

// File: doc/reg_status.md
REG_STATUS -- requirements
Module: reg_status

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 3, the ROB tag width, which equals the ROB address width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default `REG_ADDR_WIDTH (5), the architectural register index width.
REQ-003 SHALL have parameter NUM_REGS, default 1<<REG_ADDR_WIDTH (32), the number of architectural registers.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 Ports SHALL be:
- stall_i  in  1  freezes issue/commit updates.
- flush_i  in  1  clears all rename state.
- issue_en_i  in  1  dispatch allocates a ROB entry this cycle.
- issue_rd_i  in  REG_ADDR_WIDTH  destination register of the dispatching instruction.
- issue_tag_i  in  TAG_WIDTH  allocated ROB tag, which is the ROB tail tag.
- rs1_addr_i, rs2_addr_i  in  REG_ADDR_WIDTH  source register lookups.
- rs1_busy_o, rs2_busy_o  out  1  the source is pending in the ROB.
- rs1_tag_o, rs2_tag_o  out  TAG_WIDTH  ROB tag of the pending producer.
- commit_en_i  in  1  the ROB head retires this cycle (ROB reg_en).
- commit_dest_i  in  REG_ADDR_WIDTH  destination of the retiring entry.
- commit_tag_i  in  TAG_WIDTH  tag of the retiring entry (ROB head tag).
- pending_cnt_o  out  REG_ADDR_WIDTH+1  number of registers currently marked busy.

Function
REQ-006 SHALL hold, per register, a busy bit and a TAG_WIDTH tag in flops, not in RAM.
REQ-007 Lookups SHALL be combinational (zero latency) from registered state only; no bypass of same-cycle issue or commit.
REQ-008 rsN_tag_o SHALL equal the stored tag whenever rsN_busy_o=1, and SHALL be 0 otherwise.
REQ-009 Register 0 SHALL never be busy; an issue or commit to rd=0 SHALL be ignored, and lookups of x0 SHALL return busy=0, tag=0.
REQ-010 On issue_en_i=1, stall_i=0, flush_i=0, rd!=0: the next-cycle state for rd SHALL be busy=1, tag=issue_tag_i, overwriting any older pending tag.
REQ-011 On commit_en_i=1, stall_i=0, flush_i=0: busy[commit_dest_i] SHALL clear only if its stored tag equals commit_tag_i; on a mismatch (a younger producer owns the register) the entry SHALL be unchanged.
REQ-012 Simultaneous issue and commit to the same register SHALL leave busy=1 with tag=issue_tag_i; issue wins.
REQ-013 Simultaneous issue and commit to different registers SHALL both take effect.
REQ-014 stall_i=1 SHALL block all issue and commit updates; lookups SHALL remain valid.
REQ-015 flush_i=1 SHALL clear every busy bit and every tag next cycle, regardless of stall_i, issue_en_i and commit_en_i.
REQ-016 pending_cnt_o SHALL be a registered counter:
- +1 when a non-busy register becomes busy.
- -1 when a busy register clears.
- Unchanged on re-tagging a busy register.
- Net-combined when both events occur in one cycle.
- 0 on flush.
REQ-017 pending_cnt_o SHALL never exceed NUM_REGS-1 and SHALL never wrap below 0; reaching either limit SHALL be flagged by an assertion.
REQ-018 Tag wrap-around SHALL be handled by exact tag compare only; no age ordering is implied.

Reset
REQ-019 While rst=1 at a rising edge: all busy bits=0, all tags=0, pending_cnt_o=0. Therefore all lookup outputs read 0 the cycle after.
REQ-020 rst SHALL take priority over flush_i, stall_i, issue_en_i and commit_en_i, including when asserted mid-operation.

Structure
REQ-021 The TAG_WIDTH and REG_ADDR_WIDTH constants and the struct types reg_status_in/reg_status_out, grouping the issue, commit and lookup signals, SHALL live in the shared constants/struct package alongside rob_in/rob_out.
REQ-022 A single sub-module, reg_status_lookup, SHALL implement one combinational read port and SHALL be instantiated twice (rs1, rs2); no other sub-modules.

Verification
REQ-023 Reset, then look up rs1=5 and rs2=0 -> both busy=0, tag=0, pending_cnt_o=0.
REQ-024 Issue rd=5 tag=2, next cycle issue rd=5 tag=6, then commit dest=5 tag=2 -> busy=1, tag=6, pending_cnt_o=1. Then commit dest=5 tag=6 -> busy=0, cnt=0.
REQ-025 Issue rd=7 tag=3 and commit dest=7 tag=3 in the same cycle, with 7 already busy tag=3 -> busy=1, tag=3, cnt unchanged.
REQ-026 Issue rd=0 tag=1 -> x0 busy=0, cnt=0. Issue rd=9 tag=4 with stall_i=1 -> r9 busy=0.
REQ-027 Fill r1..r8 busy with tags 0..7, assert flush_i with issue_en_i=1 rd=10 -> all busy=0, cnt=0 next cycle.
REQ-028 Assert rst for one cycle while r4 is busy and a commit to r4 occurs -> r4 busy=0, cnt=0; the commit has no effect.
